// File: rtl/cdc_hs_pkg.sv
// Shared constants and helpers for the CDC handshake TX arbiter.
// Holds FSM state codes, default widths and the round-robin wrap.
package cdc_hs_pkg;

  localparam int DEF_DW          = 8;
  localparam int DEF_SYNC_STAGES = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  function automatic int rr_wrap(
    input int idx,
    input int n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdc_hs_tx_arbiter_if.sv
// Multi-bit CDC launch channel: req/ack 4-phase with data and id.
// master = source side (drives req/data/id), slave = destination.
interface cdc_hs_tx_arbiter_if #(
  parameter int DW   = 8,
  parameter int ID_W = 2
) ();

  logic            ch_req;
  logic [DW-1:0]   ch_data;
  logic [ID_W-1:0] ch_id;
  logic            ch_ack;

  modport master (
    output ch_req,
    output ch_data,
    output ch_id,
    input  ch_ack
  );

  modport slave (
    input  ch_req,
    input  ch_data,
    input  ch_id,
    output ch_ack
  );

endinterface

// File: rtl/cdc_hs_rr_arb.sv
// Combinational round-robin picker: first set bit at/after ptr.
// Ports: req, ptr in; one-hot gnt, encoded idx, any out.
module cdc_hs_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_hs_tx_arbiter.sv
// Source-side arbiter sharing one 4-phase CDC channel among N_REQ.
// Ports: clk_i/rst_i, req_vld/req_data/req_rdy, ch (master), status.
module cdc_hs_tx_arbiter
  import cdc_hs_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DW          = DEF_DW,
  parameter int ID_W        = $clog2(N_REQ),
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_vld,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_rdy,
  cdc_hs_tx_arbiter_if.master ch,
  output logic                busy,
  output logic                done,
  output logic [ID_W-1:0]     done_id,
  output logic                tout_err
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]             state_q;
  logic [ID_W-1:0]        ptr_q;
  logic [CW-1:0]          cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  logic [N_REQ-1:0]       gnt;
  logic [ID_W-1:0]        gidx;
  logic                   gany;
  logic                   grant_en;
  logic                   tout_hit;

  cdc_hs_rr_arb #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .req (req_vld),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign busy     = (state_q != ST_IDLE);
  // A stale ack from the previous transfer blocks new grants.
  assign grant_en = (state_q == ST_IDLE) && !ack_s && gany;
  assign req_rdy  = grant_en ? gnt : '0;
  assign tout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ch.ch_ack};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ch.ch_req  <= 1'b0;
      ch.ch_data <= '0;
      ch.ch_id   <= '0;
      done       <= 1'b0;
      tout_err   <= 1'b0;
      done_id    <= '0;
    end else begin
      done     <= 1'b0;
      tout_err <= 1'b0;
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          if (grant_en) begin
            ch.ch_data <= req_data[gidx*DW +: DW];
            ch.ch_id   <= gidx;
            ch.ch_req  <= 1'b1;
            ptr_q      <= ID_W'(rr_wrap(int'(gidx), N_REQ));
            state_q    <= ST_SEND;
          end
        end
        (state_q == ST_SEND): begin
          cnt_q <= cnt_q + 1'b1;
          if (ack_s) begin
            ch.ch_req <= 1'b0;
            done      <= 1'b1;
            done_id   <= ch.ch_id;
            state_q   <= ST_RELEASE;
          end else if (tout_hit) begin
            ch.ch_req <= 1'b0;
            tout_err  <= 1'b1;
            done_id   <= ch.ch_id;
            state_q   <= ST_RELEASE;
          end
        end
        (state_q == ST_RELEASE): begin
          if (!ack_s) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          ch.ch_req <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx_arbiter.sv
// Scoreboard bench for cdc_hs_tx_arbiter (N_REQ=4, TIMEOUT=16).
// Expected grants/completions are queued; a monitor pops and checks.
module tb_cdc_hs_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_vld = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_rdy;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic        tout_err;

  int          mode = 1;
  logic        man_ack = 1'b0;
  logic        loop_ack = 1'b0;
  logic [7:0]  hist = '0;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  typedef struct {
    int id;
    int data;
  } gnt_t;

  typedef struct {
    int id;
    bit tout;
    int lat;
  } cmp_t;

  gnt_t gnt_q[$];
  cmp_t cmp_q[$];

  cdc_hs_tx_arbiter_if #(.DW(8), .ID_W(2)) ch ();

  assign ch.ch_ack = (mode == 0) ? loop_ack :
                     (mode == 2) ? man_ack  : 1'b0;

  cdc_hs_tx_arbiter #(
    .N_REQ       (4),
    .DW          (8),
    .ID_W        (2),
    .SYNC_STAGES (2),
    .TIMEOUT     (16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .req_vld  (req_vld),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .ch       (ch),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .tout_err (tout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Destination model: ack echoes ch_req three negedges later.
  initial forever begin
    @(negedge clk);
    hist = {hist[6:0], ch.ch_req};
    loop_ack = hist[2];
  end

  // Monitor: grant contents, data stability, completions.
  initial begin
    logic prev_req;
    int   cyc0;
    int   cur_id;
    int   cur_data;
    bit   active;
    gnt_t g;
    cmp_t c;
    prev_req = 1'b0;
    cyc0 = 0;
    cur_id = 0;
    cur_data = 0;
    active = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_req = 1'b0;
        active = 1'b0;
      end else begin
        if (req_rdy != 4'b0) begin
          chk("rdy_onehot", $countones(req_rdy), 1);
          chk("rdy_not_busy", int'(busy), 0);
        end
        if (ch.ch_req && !prev_req) begin
          cyc0 = cyc;
          if (gnt_q.size() == 0) begin
            chk("gnt_unexpected", 1, 0);
          end else begin
            g = gnt_q.pop_front();
            chk("gnt_id", int'(ch.ch_id), g.id);
            chk("gnt_data", int'(ch.ch_data), g.data);
          end
          cur_id = int'(ch.ch_id);
          cur_data = int'(ch.ch_data);
          active = 1'b1;
        end else if (active && busy) begin
          chk("hold_data", int'(ch.ch_data), cur_data);
          chk("hold_id", int'(ch.ch_id), cur_id);
        end
        if (done || tout_err) begin
          chk("cmp_both", int'(done & tout_err), 0);
          chk("cmp_req_low", int'(ch.ch_req), 0);
          if (cmp_q.size() == 0) begin
            chk("cmp_unexpected", 1, 0);
          end else begin
            c = cmp_q.pop_front();
            chk("cmp_tout", int'(tout_err), int'(c.tout));
            chk("cmp_id", int'(done_id), c.id);
            if (c.lat >= 0) chk("cmp_lat", cyc - cyc0, c.lat);
          end
        end
        prev_req = ch.ch_req;
      end
    end
  end

  task automatic push_g(input int id, input int data);
    gnt_t g;
    g.id = id;
    g.data = data;
    gnt_q.push_back(g);
  endtask

  task automatic push_c(input int id, input bit tout, input int lat);
    cmp_t c;
    c.id = id;
    c.tout = tout;
    c.lat = lat;
    cmp_q.push_back(c);
  endtask

  task automatic wait_rdy(input int lim);
    int n;
    n = 0;
    #1;
    while (req_rdy == 4'b0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (req_rdy == 4'b0) chk("wait_rdy_bound", 0, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", int'(busy), 0);
  endtask

  task automatic grab(input logic [3:0] v, input logic [31:0] d);
    req_vld = v;
    req_data = d;
    wait_rdy(100);
    @(negedge clk);
    req_vld = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ch_req", int'(ch.ch_req), 0);
    chk("rst_ch_data", int'(ch.ch_data), 0);
    chk("rst_ch_id", int'(ch.ch_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tout", int'(tout_err), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_rdy", int'(req_rdy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request, loopback ack.
    mode = 0;
    push_g(2, 'hA5);
    push_c(2, 1'b0, -1);
    req_vld = 4'b0100;
    req_data = 32'h00A5_0000;
    #1;
    chk("single_rdy", int'(req_rdy), 'b0100);
    wait_rdy(10);
    @(negedge clk);
    req_vld = '0;
    wait_idle(60);

    // Four continuous requesters from pointer 0.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      push_g(i % 4, 'h10 + (i % 4));
      push_c(i % 4, 1'b0, -1);
    end
    req_vld = 4'b1111;
    req_data = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      wait_rdy(100);
      @(negedge clk);
    end
    req_vld = '0;
    wait_idle(60);

    // Ack never returns: timeout 16 cycles after SEND entry.
    mode = 1;
    push_g(1, 'h5A);
    push_c(1, 1'b1, 16);
    grab(4'b0010, 32'h0000_5A00);
    wait_idle(60);

    // ack_s rises exactly when the counter reaches TIMEOUT-1.
    mode = 2;
    man_ack = 1'b0;
    push_g(3, 'hC3);
    push_c(3, 1'b0, 16);
    req_vld = 4'b1000;
    req_data = 32'hC300_0000;
    wait_rdy(20);
    @(negedge clk);
    req_vld = '0;
    repeat (13) @(negedge clk);
    man_ack = 1'b1;
    repeat (6) @(negedge clk);
    man_ack = 1'b0;
    wait_idle(60);

    // Reset in SEND drops ch_req at once and clears the pointer.
    mode = 1;
    push_g(2, 'hA0);
    grab(4'b0100, 32'h00A0_0000);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", int'(ch.ch_req), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mode = 0;
    push_g(0, 'h11);
    push_c(0, 1'b0, -1);
    grab(4'b1001, 32'h9900_0011);
    wait_idle(60);

    // Stale ack in IDLE blocks grants until ack_s falls.
    mode = 2;
    man_ack = 1'b1;
    repeat (4) @(negedge clk);
    push_g(1, 'h77);
    push_c(1, 1'b0, -1);
    req_vld = 4'b0010;
    req_data = 32'h0000_7700;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stale_no_rdy", int'(req_rdy), 0);
    end
    man_ack = 1'b0;
    mode = 0;
    wait_rdy(20);
    @(negedge clk);
    req_vld = '0;
    wait_idle(60);

    repeat (3) @(negedge clk);
    chk("gnt_q_empty", gnt_q.size(), 0);
    chk("cmp_q_empty", cmp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
